// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared table-entry format, reserved markers and sequencer state encoding
package ov7670_pkg;
    localparam int ENTRY_W = 16;
    localparam logic [ENTRY_W-1:0] END_MARKER = 16'hFFFF;
    localparam logic [ENTRY_W-1:0] DELAY_MARKER = 16'hFFF0;
    localparam logic [7:0] CAMERA_ADDRESS = 8'h42;
    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE, ERROR
    } state_t;
endpackage

// File: rtl/ov7670_config_rom.sv
// ov7670_config_rom: combinational {addr, value} register table for OV7670 bring-up
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter int TABLE_SEL = 0
) (
    input  logic [7:0]         addr,
    output logic [ENTRY_W-1:0] data
);
    logic [ENTRY_W-1:0] entry;
    always_comb begin
        case (addr)
            8'd0:  entry = 16'h1280;
            8'd1:  entry = DELAY_MARKER;
            8'd2:  entry = 16'h1204;
            8'd3:  entry = 16'h1100;
            8'd4:  entry = 16'h0C00;
            8'd5:  entry = 16'h3E00;
            8'd6:  entry = 16'h8C00;
            8'd7:  entry = 16'h0400;
            8'd8:  entry = 16'h40D0;
            8'd9:  entry = 16'h3A04;
            8'd10: entry = 16'h1418;
            8'd11: entry = 16'h4F80;
            8'd12: entry = 16'h5080;
            8'd13: entry = 16'h5100;
            8'd14: entry = 16'h5222;
            8'd15: entry = 16'h535E;
            8'd16: entry = 16'h5480;
            8'd17: entry = 16'h589E;
            8'd18: entry = 16'h3DC0;
            8'd19: entry = 16'h1711;
            8'd20: entry = 16'h1861;
            8'd21: entry = 16'h32A4;
            8'd22: entry = 16'h1903;
            8'd23: entry = 16'h1A7B;
            8'd24: entry = 16'h030A;
            8'd25: entry = 16'h0E61;
            8'd26: entry = 16'h0F4B;
            8'd27: entry = 16'h1602;
            8'd28: entry = 16'h1E07;
            8'd29: entry = 16'h2102;
            8'd30: entry = 16'h2291;
            8'd31: entry = 16'h2907;
            8'd32: entry = 16'h330B;
            8'd33: entry = 16'h350B;
            8'd34: entry = 16'h371D;
            8'd35: entry = 16'h3871;
            8'd36: entry = 16'h392A;
            8'd37: entry = 16'h3C78;
            8'd38: entry = 16'h4D40;
            8'd39: entry = 16'h4E20;
            8'd40: entry = 16'h6900;
            8'd41: entry = 16'h6B4A;
            8'd42: entry = 16'h7410;
            8'd43: entry = 16'h8D4F;
            8'd44: entry = 16'h8E00;
            8'd45: entry = 16'h8F00;
            8'd46: entry = 16'h9000;
            8'd47: entry = 16'h9100;
            8'd48: entry = 16'h9600;
            8'd49: entry = 16'h9A00;
            8'd50: entry = 16'hB084;
            8'd51: entry = 16'hB10C;
            8'd52: entry = 16'hB20E;
            8'd53: entry = 16'hB382;
            8'd54: entry = 16'hB80A;
            default: entry = END_MARKER;
        endcase
    end
    assign data = TABLE_SEL == 1 ? {1'b0, addr[6:0], ~addr} : entry;
endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the OV7670 init table, feeding each write to the SCCB engine
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int INPUT_CLK_FREQ = 25000000,
    parameter int DELAY_CYCLES = INPUT_CLK_FREQ / 1000,
    parameter int ACK_TIMEOUT = 1024,
    parameter int TABLE_SEL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_config,
    input  logic       sccb_ready,
    output logic       sccb_start,
    output logic [7:0] sccb_sub_address,
    output logic [7:0] sccb_set_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] reg_index
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    state_t state;
    logic [ENTRY_W-1:0] rom_data;
    logic [TW-1:0] ack_cnt;
    logic [31:0] delay_cnt;
    logic step;
    ov7670_config_rom #(.TABLE_SEL(TABLE_SEL)) u_rom (.addr(reg_index), .data(rom_data));
    always_comb begin
        step = state == WAIT_DONE ? sccb_ready : state == DELAY && delay_cnt == '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sccb_start <= 1'b0;
            sccb_sub_address <= 8'h00;
            sccb_set_data <= 8'h00;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            reg_index <= 8'h00;
            ack_cnt <= '0;
            delay_cnt <= '0;
        end else begin
            sccb_start <= 1'b0;
            case (state)
                IDLE: if (start_config) begin
                    state <= FETCH;
                    reg_index <= 8'h00;
                    busy <= 1'b1;
                    done <= 1'b0;
                    error <= 1'b0;
                end
                FETCH: if (rom_data == END_MARKER) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else if (rom_data[ENTRY_W-1:8] == 8'hFF) begin
                    state <= DELAY;
                    delay_cnt <= rom_data == DELAY_MARKER ? 32'(DELAY_CYCLES - 1) : 32'd0;
                end else begin
                    state <= ISSUE;
                    sccb_sub_address <= rom_data[ENTRY_W-1:8];
                    sccb_set_data <= rom_data[7:0];
                    sccb_start <= sccb_ready;
                end
                ISSUE: if (sccb_start) begin
                    state <= WAIT_ACK;
                    ack_cnt <= TW'(ACK_TIMEOUT - 1);
                end else begin
                    sccb_start <= sccb_ready;
                end
                WAIT_ACK: if (!sccb_ready) begin
                    state <= WAIT_DONE;
                end else if (ack_cnt == '0) begin
                    state <= ERROR;
                    busy <= 1'b0;
                    error <= 1'b1;
                end else begin
                    ack_cnt <= ack_cnt - 1'b1;
                end
                WAIT_DONE, DELAY: if (step && reg_index == 8'hFF) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else if (step) begin
                    state <= FETCH;
                    reg_index <= reg_index + 8'd1;
                end else if (state == DELAY) begin
                    delay_cnt <= delay_cnt - 32'd1;
                end
                DONE, ERROR: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Sequences the OV7670 register initialisation over the SCCB link. It walks a register/value table held in a companion ROM and hands each pair to the SCCB write engine through its start/ready handshake. It inserts timed delays where the table requests them (e.g. after soft reset 0x12=0x80), then reports completion or a handshake error to the top-level camera/VGA pipeline.

## Interface
- INPUT_CLK_FREQ, 25000000: system clock in Hz; documentation only, used to derive DELAY_CYCLES.
- DELAY_CYCLES, 25000: length of one table-requested delay in clk cycles (1 ms at 25 MHz).
- ACK_TIMEOUT, 1024: maximum number of cycles to wait for the write engine to drop ready after a start pulse.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- start_config  in  1  level or pulse; begins a full table pass when sampled high in IDLE.
- sccb_ready  in  1  write engine ready: 1 = idle, 0 = transfer in progress.
- sccb_start  out  1  one-cycle start pulse to the write engine.
- sccb_sub_address  out  8  register address; held stable from the start pulse until the transfer completes.
- sccb_set_data  out  8  register value; held with sccb_sub_address.
- busy  out  1  high from acceptance of start_config until DONE or ERROR.
- done  out  1  sticky; set on a clean end of table, cleared by the next accepted start_config.
- error  out  1  sticky; set on an ack timeout, cleared by the next accepted start_config.
- reg_index  out  8  index of the current table entry.

## Operation
- The table entry is 16 bits: {addr[15:8], value[7:0]}.
- Reserved entries:
  - 0xFFFF = end of table.
  - 0xFFF0 = delay of DELAY_CYCLES; no SCCB write is issued.
- Register 0xFF is never written.
- States:
  - IDLE: on start_config=1, set index=0, busy=1, clear done and error, go to FETCH.
  - FETCH: register rom_data. 0xFFFF → DONE. 0xFFF0 → DELAY with counter=DELAY_CYCLES-1. Otherwise → ISSUE.
  - ISSUE: wait until sccb_ready=1, then drive sccb_start=1 for exactly one cycle, load timeout counter, go to WAIT_ACK.
  - WAIT_ACK: when sccb_ready=0, go to WAIT_DONE. When the timeout counter reaches 0, go to ERROR.
  - WAIT_DONE: when sccb_ready=1, increment index and go to FETCH. There is no timeout here; the write engine always completes.
  - DELAY: decrement the counter; at 0, increment index and go to FETCH.
  - DONE: busy=0, done=1, return to IDLE in the same transition.
  - ERROR: busy=0, error=1, return to IDLE.
- Index wrap: if index=255 completes without an end marker, go to DONE. The index never wraps to 0 mid-pass.
- start_config is ignored while busy=1. A re-run after DONE or ERROR replays the entire table.
- Reset mid-operation: all state is dropped immediately. The write engine shares the same reset, so no bus recovery is attempted.

## Timing
- Reset values: sccb_start=0, sccb_sub_address=0x00, sccb_set_data=0x00, busy=0, done=0, error=0, reg_index=0. The state register resets to IDLE.
- The ROM read is combinational on reg_index. The entry is registered in FETCH, so the outputs are stable at least one cycle before sccb_start.
- Start of pass: start_config sampled at edge N → busy=1 after N. FETCH occupies N+1. The earliest sccb_start is high during N+2 if sccb_ready=1.
- The write engine drops ready one cycle after sampling start. WAIT_ACK must therefore tolerate sccb_ready=1 in the first cycle after the pulse.
- Per-write overhead beyond the engine's own transfer: 3 cycles (FETCH, ISSUE, the WAIT_DONE exit).
- A delay entry costs exactly DELAY_CYCLES+1 cycles from entering FETCH to the next FETCH.
- The timeout counter is a clog2(ACK_TIMEOUT)-bit down-counter. The delay counter is 32 bits.

## Structure
- Shared package ov7670_pkg holds:
  - the entry width (16);
  - END_MARKER=16'hFFFF and DELAY_MARKER=16'hFFF0;
  - the state encoding constants;
  - CAMERA_ADDRESS=8'h42.
- Sub-module ov7670_config_rom: input addr[7:0], output data[15:0], a combinational case statement holding the register table. The first entries are 0x1280 and then 0xFFF0. The table ends with 0xFFFF.
- The sequencer contains only the FSM, the counters and the output registers.

## Test plan
- Basic pass, table {0x1280, 0xFFF0, 0x1101, 0xFFFF}, DELAY_CYCLES=8, behavioural engine whose ready drops 1 cycle after start and stays low 40 cycles:
  - exactly two sccb_start pulses, carrying (0x12,0x80) then (0x11,0x01);
  - the second pulse comes ≥9 cycles after the first write completes;
  - done=1 and busy=0 at the end.
- Handshake hold: sccb_ready held 0 on entry to ISSUE for 20 cycles → no sccb_start until ready rises; the pulse is one cycle wide; the address and data are unchanged throughout.
- Ack timeout: engine never drops ready, ACK_TIMEOUT=16 → error=1 and busy=0 within 18 cycles of the pulse; done stays 0; a following start_config clears error.
- Ignored restart: start_config pulsed mid-pass → the sequence, reg_index progression and pulse count are identical to the basic pass.
- Reset mid-pass: reset asserted during WAIT_DONE → all outputs at reset values asynchronously. After release plus start_config, the first pulse again carries (0x12,0x80).
- No end marker: a ROM with 256 ordinary entries → 256 pulses, then done=1 with reg_index=255.
